demux_1_to_8_regbank: RTL

//   Write-side counterpart of the 8:1 read mux. Routes one WIDTH-bit data word to
//   one of eight holding registers selected by a 3-bit code. Uses a valid/ready

---
 rtl/demux_1_to_8_regbank_if.sv | 28 ++
 rtl/demux_1_to_8_regbank.sv | 104 ++++++++++
 2 files changed

// File: rtl/demux_1_to_8_regbank_if.sv
// demux_1_to_8_regbank_if
//   Write-request bus for the 1:8 register bank.
//   wr_valid  master->slave  write request present
//   wr_ready  slave->master  bank can accept a request this cycle
//   wr_sel    master->slave  destination register index 0..7
//   wr_data   master->slave  data word to write
interface demux_1_to_8_regbank_if #(
  parameter int WIDTH = 6
);
  logic             wr_valid;
  logic             wr_ready;
  logic [2:0]       wr_sel;
  logic [WIDTH-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_sel,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_sel,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/demux_1_to_8_regbank.sv
// demux_1_to_8_regbank
//   Write side of the 8:1 read mux: routes one WIDTH-bit word into one of eight
//   holding registers chosen by a 3-bit code. A request is captured into a
//   one-entry pending stage (IDLE -> COMMIT) and written to its register on the
//   following edge, so peak throughput is one write every two cycles.
// Ports
//   clk      clock, all state changes on the rising edge
//   reset    synchronous active-high reset
//   bus      write request bus (slave side): wr_valid, wr_ready, wr_sel, wr_data
//   clr      synchronous clear of all registers and written flags
//   q0..q7   register contents
//   written  bit k set once qk has been written since the last reset/clr
//   wr_done  one-cycle pulse in the cycle following a commit
module demux_1_to_8_regbank #(
  parameter int WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  demux_1_to_8_regbank_if.slave   bus,
  input  logic                    clr,
  output logic [WIDTH-1:0]        q0,
  output logic [WIDTH-1:0]        q1,
  output logic [WIDTH-1:0]        q2,
  output logic [WIDTH-1:0]        q3,
  output logic [WIDTH-1:0]        q4,
  output logic [WIDTH-1:0]        q5,
  output logic [WIDTH-1:0]        q6,
  output logic [WIDTH-1:0]        q7,
  output logic [7:0]              written,
  output logic                    wr_done
);

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t           state_q;
  logic [2:0]       pend_sel_q;
  logic [WIDTH-1:0] pend_data_q;
  logic [WIDTH-1:0] regs_q [8];
  logic [7:0]       written_q;
  logic             wr_done_q;
  logic             accept;

  // Ready is a function of state, clr and reset only; the request bus never
  // feeds it, so there is no loop through the master's valid logic.
  assign bus.wr_ready = (state_q == IDLE) && !clr && !reset;
  assign accept       = bus.wr_valid && bus.wr_ready;

  // Stage boundary: request -> pending entry. Pending contents are data only;
  // they are meaningful solely while in COMMIT, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_sel_q  <= bus.wr_sel;
      pend_data_q <= bus.wr_data;
    end
  end

  // Stage boundary: pending entry -> register bank, plus control FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      written_q <= 8'h00;
      wr_done_q <= 1'b0;
      for (int k = 0; k < 8; k++) regs_q[k] <= '0;
    end else if (clr) begin
      // A write sitting in COMMIT is dropped along with everything else.
      state_q   <= IDLE;
      written_q <= 8'h00;
      wr_done_q <= 1'b0;
      for (int k = 0; k < 8; k++) regs_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wr_done_q <= 1'b0;
          if (accept) state_q <= COMMIT;
        end
        COMMIT: begin
          regs_q[pend_sel_q]    <= pend_data_q;
          written_q[pend_sel_q] <= 1'b1;
          wr_done_q             <= 1'b1;
          state_q               <= IDLE;
        end
        default: begin
          wr_done_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign q0      = regs_q[0];
  assign q1      = regs_q[1];
  assign q2      = regs_q[2];
  assign q3      = regs_q[3];
  assign q4      = regs_q[4];
  assign q5      = regs_q[5];
  assign q6      = regs_q[6];
  assign q7      = regs_q[7];
  assign written = written_q;
  assign wr_done = wr_done_q;

endmodule
